// File: rtl/decryption_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// decryption_cfg_sequencer
//
// Bus master that programs the decryption register file after a start pulse.
// It writes the select, Caesar, Scytale and ZigZag key registers from values
// latched at start. With VERIFY set, it then reads each register back and
// compares the masked readback against the written value.
//
// Parameters
//   VERIFY      1: write, then read back and compare; 0: write only
//   TIMEOUT     cycles to wait for done after a request before aborting
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start             one-cycle request, accepted only while idle
//   select_val        value for register 0x00 (only bits [1:0] are compared)
//   caesar_val        value for register 0x10
//   scytale_val       value for register 0x12
//   zigzag_val        value for register 0x14
//   addr/read/write/wdata   register file request (all registered)
//   rdata/done/error        register file response
//   busy              sequence in progress
//   cfg_done          one-cycle pulse on successful completion
//   cfg_error         sticky failure flag, cleared by the next accepted start
//   fail_addr         address of the failing access
// -----------------------------------------------------------------------------
module decryption_cfg_sequencer #(
    parameter int unsigned VERIFY  = 1,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] select_val,
    input  logic [15:0] caesar_val,
    input  logic [15:0] scytale_val,
    input  logic [15:0] zigzag_val,
    output logic [7:0]  addr,
    output logic        read,
    output logic        write,
    output logic [15:0] wdata,
    input  logic [15:0] rdata,
    input  logic        done,
    input  logic        error,
    output logic        busy,
    output logic        cfg_done,
    output logic        cfg_error,
    output logic [7:0]  fail_addr
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_REQ  = 3'd1;
    localparam logic [2:0] S_WR_WAIT = 3'd2;
    localparam logic [2:0] S_RD_REQ  = 3'd3;
    localparam logic [2:0] S_RD_WAIT = 3'd4;
    localparam logic [2:0] S_FINISH  = 3'd5;
    localparam logic [2:0] S_FAIL    = 3'd6;

    localparam int            CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [7:0] tbl_addr(input logic [1:0] i);
        case (i)
            2'd0:    tbl_addr = 8'h00;
            2'd1:    tbl_addr = 8'h10;
            2'd2:    tbl_addr = 8'h12;
            default: tbl_addr = 8'h14;
        endcase
    endfunction

    // The select register only implements its two low bits.
    function automatic logic [15:0] tbl_mask(input logic [1:0] i);
        tbl_mask = (i == 2'd0) ? 16'h0003 : 16'hFFFF;
    endfunction

    logic [2:0]       state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0][15:0] val_q, val_d;
    logic [7:0]       addr_q, addr_d;
    logic [15:0]      wdata_q, wdata_d;
    logic             read_q, read_d;
    logic             write_q, write_d;
    logic             busy_q, busy_d;
    logic             cfg_done_q, cfg_done_d;
    logic             cfg_error_q, cfg_error_d;
    logic [7:0]       fail_addr_q, fail_addr_d;

    logic [CNT_W-1:0] cnt_inc;
    logic             timed_out;
    logic             rd_mismatch;

    // Saturating increment: the counter can never wrap back below the limit.
    assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    assign timed_out   = (cnt_inc >= CNT_LIM);
    assign rd_mismatch = (((rdata ^ val_q[idx_q]) & tbl_mask(idx_q)) != 16'h0000);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        val_d       = val_q;
        cfg_error_d = cfg_error_q;
        fail_addr_d = fail_addr_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_WR_REQ;
                    idx_d       = 2'd0;
                    val_d       = {zigzag_val, scytale_val, caesar_val, select_val};
                    cfg_error_d = 1'b0;
                    fail_addr_d = 8'h00;
                end
            end
            S_WR_REQ: begin
                state_d = S_WR_WAIT;
                cnt_d   = '0;
            end
            S_WR_WAIT: begin
                if (done) begin
                    if (error) begin
                        state_d = S_FAIL;
                    end else if (idx_q == 2'd3) begin
                        state_d = (VERIFY != 0) ? S_RD_REQ : S_FINISH;
                        idx_d   = 2'd0;
                    end else begin
                        state_d = S_WR_REQ;
                        idx_d   = idx_q + 2'd1;
                    end
                end else if (timed_out) begin
                    state_d = S_FAIL;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_RD_REQ: begin
                state_d = S_RD_WAIT;
                cnt_d   = '0;
            end
            S_RD_WAIT: begin
                if (done) begin
                    if (error || rd_mismatch) begin
                        state_d = S_FAIL;
                    end else if (idx_q == 2'd3) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_RD_REQ;
                        idx_d   = idx_q + 2'd1;
                    end
                end else if (timed_out) begin
                    state_d = S_FAIL;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_FINISH: state_d = S_IDLE;
            S_FAIL:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // Failure is only entered from a wait state, where idx still names
        // the access that went wrong.
        if (state_d == S_FAIL && state_q != S_FAIL) begin
            cfg_error_d = 1'b1;
            fail_addr_d = tbl_addr(idx_q);
        end

        // Outputs are registered from the next state so that they line up
        // with the state they belong to.
        write_d    = (state_d == S_WR_REQ);
        read_d     = (state_d == S_RD_REQ);
        busy_d     = (state_d != S_IDLE);
        cfg_done_d = (state_d == S_FINISH);
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if (state_d == S_WR_REQ || state_d == S_RD_REQ) begin
            addr_d = tbl_addr(idx_d);
        end
        if (state_d == S_WR_REQ) begin
            wdata_d = val_d[idx_d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= 2'd0;
            cnt_q       <= '0;
            addr_q      <= 8'h00;
            wdata_q     <= 16'h0000;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            busy_q      <= 1'b0;
            cfg_done_q  <= 1'b0;
            cfg_error_q <= 1'b0;
            fail_addr_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            read_q      <= read_d;
            write_q     <= write_d;
            busy_q      <= busy_d;
            cfg_done_q  <= cfg_done_d;
            cfg_error_q <= cfg_error_d;
            fail_addr_q <= fail_addr_d;
        end
    end

    // Latched values are pure data and need no reset.
    always_ff @(posedge clk) begin
        val_q <= val_d;
    end

    assign addr      = addr_q;
    assign wdata     = wdata_q;
    assign read      = read_q;
    assign write     = write_q;
    assign busy      = busy_q;
    assign cfg_done  = cfg_done_q;
    assign cfg_error = cfg_error_q;
    assign fail_addr = fail_addr_q;

endmodule

// File: tb/tb_decryption_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for decryption_cfg_sequencer. A behavioural register file answers
// each strobe with done one cycle later; the driver pushes the expected
// strobes and completion events into a queue and a monitor pops and compares
// them as the DUT presents them.
// -----------------------------------------------------------------------------
module tb_decryption_cfg_sequencer;

    localparam int EV_W    = 0;
    localparam int EV_R    = 1;
    localparam int EV_DONE = 2;
    localparam int EV_FAIL = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] select_val = '0, caesar_val = '0, scytale_val = '0, zigzag_val = '0;
    logic [7:0]  addr;
    logic        read, write;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        done, error;
    logic        busy, cfg_done, cfg_error;
    logic [7:0]  fail_addr;

    decryption_cfg_sequencer #(.VERIFY(1), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .start(start),
        .select_val(select_val), .caesar_val(caesar_val),
        .scytale_val(scytale_val), .zigzag_val(zigzag_val),
        .addr(addr), .read(read), .write(write), .wdata(wdata),
        .rdata(rdata), .done(done), .error(error),
        .busy(busy), .cfg_done(cfg_done), .cfg_error(cfg_error),
        .fail_addr(fail_addr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int base   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural register file with fault injection knobs.
    logic        hang_en = 1'b0;    logic [7:0] hang_addr = '0;
    logic        err_en = 1'b0;     logic [7:0] err_addr = '0;
    logic        corrupt_en = 1'b0; logic [7:0] corrupt_addr = '0;
    logic [15:0] mem [256];

    always @(posedge clk) begin
        if (rst) begin
            done  <= 1'b0;
            error <= 1'b0;
            rdata <= 16'h0000;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            if (write) begin
                if (!(hang_en && addr == hang_addr)) begin
                    done  <= 1'b1;
                    error <= err_en && (addr == err_addr);
                end
                mem[addr] <= (addr == 8'h00) ? (wdata & 16'h0003) : wdata;
            end else if (read) begin
                done  <= 1'b1;
                rdata <= (corrupt_en && addr == corrupt_addr) ? 16'h0007 : mem[addr];
            end
        end
    end

    typedef struct {
        int          kind;
        logic [7:0]  a;
        logic [15:0] d;
        int          c;
    } ev_t;

    ev_t exp_q[$];

    task automatic push(input int kind, input logic [7:0] a, input logic [15:0] d, input int c);
        ev_t e;
        e.kind = kind; e.a = a; e.d = d; e.c = c;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_evt(input string name, input int kind, input logic [7:0] a, input logic [15:0] d);
        ev_t e;
        int  rel;
        rel = cyc - base;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected: kind %0d addr 0x%0h data 0x%0h cycle %0d, none expected", name, kind, a, d, rel);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.a !== a || (kind == EV_W && e.d !== d) || e.c != rel) begin
                errors++;
                $display("FAIL %s: got kind %0d addr 0x%0h data 0x%0h cycle %0d; want kind %0d addr 0x%0h data 0x%0h cycle %0d",
                         name, kind, a, d, rel, e.kind, e.a, e.d, e.c);
            end
        end
    endtask

    // Monitor: compares every presented strobe / completion against the queue.
    logic err_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (read && write) chk("strobe_overlap", {read, write}, 2'b00);
            if (write)         check_evt("write", EV_W, addr, wdata);
            if (read)          check_evt("read", EV_R, addr, 16'h0000);
            if (cfg_done)      check_evt("cfg_done", EV_DONE, 8'h00, 16'h0000);
            if (cfg_error && !err_prev) check_evt("cfg_error", EV_FAIL, fail_addr, 16'h0000);
        end
        err_prev = cfg_error;
    end

    task automatic set_vals(input logic [15:0] s, input logic [15:0] c, input logic [15:0] sc, input logic [15:0] z);
        select_val = s; caesar_val = c; scytale_val = sc; zigzag_val = z;
    endtask

    task automatic push_writes(input int n);
        logic [7:0]  a [4];
        logic [15:0] v [4];
        a[0] = 8'h00; a[1] = 8'h10; a[2] = 8'h12; a[3] = 8'h14;
        v[0] = select_val; v[1] = caesar_val; v[2] = scytale_val; v[3] = zigzag_val;
        for (int i = 0; i < n; i++) push(EV_W, a[i], v[i], 1 + 2 * i);
    endtask

    task automatic push_reads(input int n);
        logic [7:0] a [4];
        a[0] = 8'h00; a[1] = 8'h10; a[2] = 8'h12; a[3] = 8'h14;
        for (int i = 0; i < n; i++) push(EV_R, a[i], 16'h0000, 9 + 2 * i);
    endtask

    // Start sampled at edge 0; base makes the cycle after that edge cycle 1.
    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        base  = cyc - 1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk({name, "_idle_timeout"}, 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        chk({name, "_queue_drained"}, exp_q.size(), 0);
    endtask

    task automatic clear_faults();
        hang_en = 1'b0; err_en = 1'b0; corrupt_en = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {addr, wdata, read, write, busy, cfg_done, cfg_error, fail_addr}, '0);
        @(negedge clk);
        rst = 1'b0;

        // Nominal write and verify.
        set_vals(16'h0002, 16'hBCA2, 16'h0003, 16'h0004);
        push_writes(4); push_reads(4); push(EV_DONE, 8'h00, 16'h0000, 17);
        start_pulse();
        set_vals(16'h1111, 16'h2222, 16'h3333, 16'h4444);   // must not affect the run
        @(negedge clk);
        chk("busy_cycle1", busy, 1'b1);
        wait_idle("nominal", 60);
        chk("nominal_err", cfg_error, 1'b0);

        // Select masking: only bits [1:0] are stored and compared.
        set_vals(16'hFFF1, 16'h1234, 16'h5678, 16'h9ABC);
        push_writes(4); push_reads(4); push(EV_DONE, 8'h00, 16'h0000, 17);
        start_pulse();
        wait_idle("masking", 60);
        chk("masking_err", cfg_error, 1'b0);

        // Readback mismatch on Scytale.
        clear_faults(); corrupt_en = 1'b1; corrupt_addr = 8'h12;
        set_vals(16'h0002, 16'hBCA2, 16'h0003, 16'h0004);
        push_writes(4); push_reads(3); push(EV_FAIL, 8'h12, 16'h0000, 15);
        start_pulse();
        wait_idle("mismatch", 60);
        chk("mismatch_sticky_err", cfg_error, 1'b1);
        chk("mismatch_fail_addr", fail_addr, 8'h12);

        // Error reported on the write to 0x14: no reads follow.
        clear_faults(); err_en = 1'b1; err_addr = 8'h14;
        push_writes(4); push(EV_FAIL, 8'h14, 16'h0000, 9);
        start_pulse();
        @(negedge clk);
        chk("restart_clears_err", cfg_error, 1'b0);
        wait_idle("wr_error", 60);
        chk("wr_error_fail_addr", fail_addr, 8'h14);

        // Timeout: 0x10 never completes; WR_WAIT entered in cycle 4, FAIL in 19.
        clear_faults(); hang_en = 1'b1; hang_addr = 8'h10;
        push_writes(2); push(EV_FAIL, 8'h10, 16'h0000, 19);
        start_pulse();
        wait_idle("timeout", 60);
        chk("timeout_fail_addr", fail_addr, 8'h10);
        chk("timeout_sticky_err", cfg_error, 1'b1);

        // Start re-pulsed while busy is ignored.
        clear_faults();
        set_vals(16'h0001, 16'hA5A5, 16'h5A5A, 16'h0F0F);
        push_writes(4); push_reads(4); push(EV_DONE, 8'h00, 16'h0000, 17);
        start_pulse();
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("repulse", 60);

        // Reset in RD_WAIT (cycle 10) clears everything on that edge.
        set_vals(16'h0002, 16'hBCA2, 16'h0003, 16'h0004);
        push_writes(4); push_reads(1);
        start_pulse();
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrun_rst_outputs", {addr, wdata, read, write, busy, cfg_done, cfg_error, fail_addr}, '0);
        chk("midrun_rst_queue", exp_q.size(), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("after_rst_idle", {busy, cfg_done, read, write}, 4'b0000);

        // A following start completes normally.
        set_vals(16'h0003, 16'hCAFE, 16'hBEEF, 16'hF00D);
        push_writes(4); push_reads(4); push(EV_DONE, 8'h00, 16'h0000, 17);
        start_pulse();
        wait_idle("post_rst", 60);
        chk("post_rst_err", cfg_error, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, want finish before 200000");
        $fatal(1);
    end

endmodule
